// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared constants, FSM encoding and address helpers for cache_ctrl_2way
package cache_ctrl_pkg;

  localparam int DEF_ADDR_BASE      = 1024;
  localparam int DEF_ADDR_BITS      = 20;
  localparam int DEF_WORDS_PER_LINE = 2;
  localparam int DEF_SET_BITS       = 6;

  localparam int OFF      = $clog2(DEF_WORDS_PER_LINE);
  localparam int TAG_BITS = DEF_ADDR_BITS - OFF - DEF_SET_BITS - 2;
  localparam int SETS     = 1 << DEF_SET_BITS;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_REFILL = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  // Callers truncate the result to the field width, which drops the upper bits.
  function automatic logic [31:0] addr_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  function automatic logic [31:0] addr_set(input logic [31:0] a, input int off);
    return a >> (off + 2);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off, input int set_bits);
    return a >> (off + set_bits + 2);
  endfunction

endpackage

// File: rtl/cache_ctrl_2way_if.sv
// rtl/cache_ctrl_2way_if.sv - MEM-stage request and SRAM-side bus of the two-way cache
interface cache_ctrl_2way_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic        sram_write_en;
  logic        sram_read_en;
  logic [31:0] sram_read_data;
  logic        sram_ready;

  modport slave (
    input  address, writeData, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
    output rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en
  );

  modport master (
    output address, writeData, MEM_R_EN, MEM_W_EN, sram_read_data, sram_ready,
    input  rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en
  );
endinterface

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one cache way: tag/data storage, valid flops, tag compare and word read
module cache_way_array #(
  parameter int TAG_W    = 11,
  parameter int SET_BITS = 6,
  parameter int WORDS    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SET_BITS-1:0]         set_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [$clog2(WORDS)-1:0]    word_i,
  output logic                        hit_o,
  output logic [31:0]                 rdata_o,
  input  logic                        line_we_i,
  input  logic [31:0]                 line_i [WORDS],
  input  logic                        word_we_i,
  input  logic [31:0]                 wdata_i
);

  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  assign hit_o   = valid_q[set_i] && (tag_q[set_i] == tag_i);
  assign rdata_o = data_q[set_i][word_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[set_i] <= 1'b1;
    end
  end

  // Tag and data are left unreset; the valid bit alone gates their use.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[set_i] <= tag_i;
      for (int w = 0; w < WORDS; w++) begin
        data_q[set_i][w] <= line_i[w];
      end
    end else if (word_we_i) begin
      data_q[set_i][word_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/cache_ctrl_2way.sv
// rtl/cache_ctrl_2way.sv - two-way set-associative write-through read cache with LRU replacement
module cache_ctrl_2way
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_BASE      = DEF_ADDR_BASE,
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int SET_BITS       = DEF_SET_BITS
) (
  input logic               clk,
  input logic               rst,
  cache_ctrl_2way_if.slave  bus
);

  localparam int OFF_L  = $clog2(WORDS_PER_LINE);
  localparam int TAG_L  = ADDR_BITS - OFF_L - SET_BITS - 2;
  localparam int SETS_L = 1 << SET_BITS;
  localparam logic [OFF_L-1:0] LAST_BEAT = OFF_L'(WORDS_PER_LINE - 1);

  logic [31:0]         rebased;
  logic [SET_BITS-1:0] set_idx;
  logic [TAG_L-1:0]    tag;
  logic [OFF_L-1:0]    word;
  logic [31:0]         line_base;

  assign rebased   = bus.address - 32'(ADDR_BASE);
  assign set_idx   = SET_BITS'(addr_set(rebased, OFF_L));
  assign tag       = TAG_L'(addr_tag(rebased, OFF_L, SET_BITS));
  assign word      = OFF_L'(addr_word(rebased));
  assign line_base = bus.address & ~((32'd1 << (OFF_L + 2)) - 32'd1);

  logic [2:0]       state_q, state_d;
  logic [OFF_L-1:0] k_q, k_d;
  logic [31:0]      line_buf_q [WORDS_PER_LINE];
  logic             buf_we;
  logic [SETS_L-1:0] lru_q;
  logic             lru_we, lru_val;
  logic [1:0]       hit_w, line_we, word_we;
  logic [31:0]      rd_w [2];
  logic             hit, hit_way, victim;
  logic [31:0]      hit_data;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way_array #(
      .TAG_W    (TAG_L),
      .SET_BITS (SET_BITS),
      .WORDS    (WORDS_PER_LINE)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .set_i     (set_idx),
      .tag_i     (tag),
      .word_i    (word),
      .hit_o     (hit_w[g]),
      .rdata_o   (rd_w[g]),
      .line_we_i (line_we[g]),
      .line_i    (line_buf_q),
      .word_we_i (word_we[g]),
      .wdata_i   (bus.writeData)
    );
  end

  assign hit      = |hit_w;
  assign hit_way  = hit_w[1];
  assign hit_data = rd_w[hit_way];
  assign victim   = lru_q[set_idx];

  always_comb begin
    state_d             = state_q;
    k_d                 = k_q;
    buf_we              = 1'b0;
    line_we             = '0;
    word_we             = '0;
    lru_we              = 1'b0;
    lru_val             = 1'b0;
    bus.rdata           = '0;
    bus.ready           = 1'b0;
    bus.sram_address    = '0;
    bus.sram_write_data = '0;
    bus.sram_write_en   = 1'b0;
    bus.sram_read_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MEM_R_EN)      state_d = ST_LOOKUP;
        else if (bus.MEM_W_EN) state_d = ST_WRITE;
      end
      ST_LOOKUP: begin
        if (hit) begin
          bus.ready = 1'b1;
          bus.rdata = hit_data;
          lru_we    = 1'b1;
          lru_val   = ~hit_way;
          state_d   = ST_IDLE;
        end else begin
          k_d     = '0;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = line_base + 32'({k_q, 2'b00});
        if (bus.sram_ready) begin
          buf_we = 1'b1;
          if (k_q == LAST_BEAT) state_d = ST_FILL;
          else                  k_d     = k_q + OFF_L'(1);
        end
      end
      ST_FILL: begin
        line_we[victim] = 1'b1;
        lru_we          = 1'b1;
        lru_val         = ~victim;
        bus.ready       = 1'b1;
        bus.rdata       = line_buf_q[word];
        state_d         = ST_IDLE;
      end
      ST_WRITE: begin
        bus.sram_write_en   = 1'b1;
        bus.sram_address    = bus.address;
        bus.sram_write_data = bus.writeData;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          if (hit) begin
            word_we[hit_way] = 1'b1;
            lru_we           = 1'b1;
            lru_val          = ~hit_way;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (lru_we) lru_q[set_idx] <= lru_val;
    end
  end

  // A reset mid-refill leaves stale beats here, but they are never written to a way.
  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[k_q] <= bus.sram_read_data;
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// tb/tb_cache_ctrl_2way.sv - directed table-driven bench for cache_ctrl_2way with a random-latency SRAM
module tb_cache_ctrl_2way;
  import cache_ctrl_pkg::*;

  localparam int WPL    = 1 << OFF;
  localparam int STRIDE = SETS * WPL * 4;
  localparam logic [31:0] A0   = 32'h500;
  localparam logic [31:0] A1   = A0 + 32'(STRIDE);
  localparam logic [31:0] A2   = A0 + 32'(2 * STRIDE);
  localparam logic [31:0] A3   = A0 + 32'(8 * STRIDE);
  localparam logic [31:0] A4   = A0 + 32'(10 * STRIDE);
  localparam logic [31:0] AMAX = 32'h400 + 32'(((1 << TAG_BITS) - 1) * STRIDE);
  localparam logic [31:0] SCRAMBLE = 32'hA5A50000;
  localparam int NVEC = 18;

  typedef struct {
    logic        is_wr;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_ctrl_2way_if bus();

  cache_ctrl_2way #(
    .ADDR_BASE      (1024),
    .ADDR_BITS      (20),
    .WORDS_PER_LINE (2),
    .SET_BITS       (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int lat_sum = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q [$];
  logic [31:0] wr_a_q [$];
  logic [31:0] wr_d_q [$];
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ SCRAMBLE);
  endfunction

  function automatic vec_t mk(input logic w, input logic b, input logic [31:0] a,
                              input logic [31:0] d, input logic h, input logic [31:0] r);
    vec_t v;
    v.is_wr = w; v.both = b; v.addr = a; v.wdata = d; v.exp_hit = h; v.exp_rdata = r;
    return v;
  endfunction

  // SRAM: each access takes 1..4 cycles; ready is computed just after the edge.
  initial begin
    int cnt;
    cnt = 0;
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = 32'hBAADF00D;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (bus.sram_read_en || bus.sram_write_en)) begin
        if (cnt == 0) begin
          cnt = $urandom_range(4, 1);
          lat_sum += cnt;
        end
        cnt--;
        if (cnt == 0) begin
          bus.sram_ready = 1'b1;
          if (bus.sram_read_en) bus.sram_read_data = sram_val(bus.sram_address);
          else                  mem[bus.sram_address] = bus.sram_write_data;
        end else begin
          bus.sram_ready     = 1'b0;
          bus.sram_read_data = 32'hBAADF00D;
        end
      end else begin
        cnt = 0;
        bus.sram_ready     = 1'b0;
        bus.sram_read_data = 32'hBAADF00D;
      end
    end
  end

  initial begin
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.sram_read_en && bus.sram_ready) rd_q.push_back(bus.sram_address);
      if (!rst && bus.sram_write_en && bus.sram_ready) begin
        wr_a_q.push_back(bus.sram_address);
        wr_d_q.push_back(bus.sram_write_data);
      end
      if (bus.ready) chk("ready_back_to_back", 32'(prev_ready), 32'd0);
      prev_ready = bus.ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_idle(input string tag);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
    chk({tag, "_sram_addr"}, bus.sram_address, 32'd0);
    chk({tag, "_sram_wdata"}, bus.sram_write_data, 32'd0);
    chk({tag, "_sram_en"}, 32'({bus.sram_write_en, bus.sram_read_en}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cycles;
    int exp_cyc;
    logic got;
    logic [31:0] rdata_s;
    logic [31:0] base;
    lat_sum = 0;
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    bus.address   = v.addr;
    bus.writeData = v.wdata;
    bus.MEM_R_EN  = !v.is_wr || v.both;
    bus.MEM_W_EN  = v.is_wr || v.both;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 64) begin
      @(negedge clk);
      cycles++;
      if (bus.ready) got = 1'b1;
    end
    rdata_s = bus.rdata;
    #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    chk({tag, "_ready_seen"}, 32'(got), 32'd1);
    base = v.addr & ~((32'd1 << (OFF + 2)) - 32'd1);
    if (!v.is_wr) begin
      chk({tag, "_rdata"}, rdata_s, v.exp_rdata);
      exp_cyc = v.exp_hit ? 1 : 2 + lat_sum;
      chk({tag, "_sram_reads"}, 32'(rd_q.size()), v.exp_hit ? 32'd0 : 32'(WPL));
      if (!v.exp_hit && rd_q.size() == WPL)
        for (int i = 0; i < WPL; i++)
          chk($sformatf("%s_beat%0d_addr", tag, i), rd_q[i], base + 32'(4 * i));
    end else begin
      exp_cyc = lat_sum;
      chk({tag, "_sram_reads"}, 32'(rd_q.size()), 32'd0);
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(exp_cyc));
    chk({tag, "_sram_writes"}, 32'(wr_a_q.size()), (v.is_wr && !v.both) ? 32'd1 : 32'd0);
    if (wr_a_q.size() == 1) begin
      chk({tag, "_wr_addr"}, wr_a_q[0], v.addr);
      chk({tag, "_wr_data"}, wr_d_q[0], v.wdata);
    end
    @(negedge clk);
    check_idle({tag, "_idle"});
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.address   = '0;
    bus.writeData = '0;
    bus.MEM_R_EN  = 1'b0;
    bus.MEM_W_EN  = 1'b0;
    mem[A0] = 32'h11;  mem[A0 + 4] = 32'h22;
    mem[A1] = 32'h33;  mem[A1 + 4] = 32'h44;
    mem[A2] = 32'h55;  mem[A2 + 4] = 32'h66;
    mem[A3] = 32'h77;

    vecs[0]  = mk(0, 0, A0,     0,            0, 32'h11);
    vecs[1]  = mk(0, 0, A0 + 4, 0,            1, 32'h22);
    vecs[2]  = mk(1, 0, A0,     32'hDEADBEEF, 1, 0);
    vecs[3]  = mk(0, 0, A0,     0,            1, 32'hDEADBEEF);
    vecs[4]  = mk(0, 0, A1,     0,            0, 32'h33);
    vecs[5]  = mk(0, 0, A0,     0,            1, 32'hDEADBEEF);
    vecs[6]  = mk(0, 0, A2,     0,            0, 32'h55);
    vecs[7]  = mk(0, 0, A0,     0,            1, 32'hDEADBEEF);
    vecs[8]  = mk(0, 0, A1,     0,            0, 32'h33);
    vecs[9]  = mk(1, 0, A3,     32'h12345678, 0, 0);
    vecs[10] = mk(0, 0, A3,     0,            0, 32'h12345678);
    vecs[11] = mk(0, 0, A1 + 4, 0,            1, 32'h44);
    vecs[12] = mk(0, 0, A0 + 4, 0,            0, 32'h22);
    vecs[13] = mk(1, 0, A1 + 4, 32'hCAFEF00D, 1, 0);
    vecs[14] = mk(0, 0, A1 + 4, 0,            1, 32'hCAFEF00D);
    vecs[15] = mk(0, 1, A1 + 4, 32'hBAD0BAD0, 1, 32'hCAFEF00D);
    vecs[16] = mk(0, 0, AMAX,   0,            0, AMAX ^ SCRAMBLE);
    vecs[17] = mk(0, 0, AMAX,   0,            1, AMAX ^ SCRAMBLE);

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a refill, right after the first beat lands.
    lat_sum = 0;
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    bus.address  = A4;
    bus.MEM_R_EN = 1'b1;
    n = 0;
    while (rd_q.size() == 0 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_beat0_seen", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() > 0) chk("abort_beat0_addr", rd_q[0], A4);
    @(negedge clk);
    rst          = 1'b1;
    bus.MEM_R_EN = 1'b0;
    @(negedge clk);
    check_idle("abort");
    rst = 1'b0;
    @(negedge clk);
    run_vec(mk(0, 0, A4, 0, 0, A4 ^ SCRAMBLE), "post_abort");
    run_vec(mk(0, 0, A0, 0, 0, 32'hDEADBEEF), "post_reset_a0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_2way.md
# cache_ctrl_2way

Parametrised two-way set-associative, write-through read cache controller between the MEM stage and the SRAM controller. Successor to the direct-mapped controller: configurable line length and set count, LRU replacement, and write-hit update instead of line invalidation. Reads hit in one cycle. Misses refill a whole line word-by-word from SRAM. Writes always go through to SRAM.

## Interface
- `ADDR_BASE`, default 1024: data-memory base, subtracted from `address` before mapping.
- `ADDR_BITS`, default 20: low bits of the rebased address that are used.
- `WORDS_PER_LINE`, default 2: 32-bit words per line; power of two, ≥2.
- `SET_BITS`, default 6: log2 of the number of sets.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `address` in 32: MEM-stage byte address; word aligned.
- `writeData` in 32: store data.
- `MEM_R_EN` in 1: load request; held until `ready`.
- `MEM_W_EN` in 1: store request; held until `ready`.
- `rdata` out 32: load data; valid only while `ready`=1, otherwise 0.
- `ready` out 1: one-cycle completion pulse.
- `sram_address` out 32: SRAM byte address; 0 when idle.
- `sram_write_data` out 32: SRAM store data; 0 when idle.
- `sram_write_en` out 1: SRAM write request.
- `sram_read_en` out 1: SRAM read request.
- `sram_read_data` in 32: SRAM read data.
- `sram_ready` in 1: SRAM access complete; sampled each cycle.

## Operation
- Address map: `a = address - ADDR_BASE`. Let OFF = log2(WORDS_PER_LINE).
  - Word = `a[OFF+1:2]`.
  - Set = `a[OFF+SET_BITS+1:OFF+2]`.
  - Tag = `a[ADDR_BITS-1:OFF+SET_BITS+2]`.
  - Line base = `address` with bits [OFF+1:0] cleared.
- Per set: two ways, each holding valid, tag and a data line, plus one LRU bit that names the victim way.
- FSM states: `IDLE`, `LOOKUP`, `REFILL`, `FILL`, `WRITE`.
  - `IDLE`: `MEM_R_EN` → `LOOKUP`. Else `MEM_W_EN` → `WRITE`. If both are high, the read wins.
  - `LOOKUP`: hit → `ready`=1, `rdata` = hit word, LRU points away from the hit way, → `IDLE`. Miss → clear the beat counter k, → `REFILL`.
  - `REFILL`: `sram_read_en`=1, `sram_address` = line base + 4k.
    - On `sram_ready`: capture `sram_read_data` into line-buffer word k, k++.
    - After the last word → `FILL`.
  - `FILL`: write the tag and line buffer into the LRU way, set valid, flip LRU. `ready`=1, `rdata` = line-buffer[word]. → `IDLE`.
  - `WRITE`: `sram_write_en`=1, `sram_address` = `address`, `sram_write_data` = `writeData`.
    - On `sram_ready`: `ready`=1. If hit, overwrite that word in the hit way and update LRU. If miss, no allocation. → `IDLE`.
- A write never invalidates a line.
- Valid and LRU bits are flops cleared by `rst`. Tag and data storage is not reset.
- Outputs are combinational from state and held inputs; every output is 0 in `IDLE`.

## Timing
- Read hit: request in cycle 0 (`IDLE`), `ready` in cycle 1. Next request accepted in cycle 2.
- Read miss: 1 (`LOOKUP`) + Σ per-beat SRAM wait + 1 (`FILL`) cycles. `ready` falls in the `FILL` cycle.
- Write: `ready` in the same cycle that `sram_ready` is high in `WRITE`.
- SRAM enables stay asserted until `sram_ready` is seen. The address changes only after a beat completes.
- The requester holds `address`, `writeData` and the enables stable until `ready`.
- Reset in any state:
  - Next cycle: `IDLE`, all outputs 0, all valid bits 0, LRU 0.
  - An in-progress refill is discarded with no partial line written.
  - The controller ignores `sram_ready` for the aborted beat.
- `ready` is never asserted for two consecutive cycles.

## Structure
- Package `cache_ctrl_pkg` holds:
  - the state enum;
  - localparams OFF, TAG_BITS, SETS;
  - set/tag/word extraction functions.
- Sub-module `cache_way_array`: one way, with tag/data arrays, valid flops, a combinational tag compare and word read, and a line or single-word write port. Instantiated twice.
- The LRU vector, FSM, beat counter and line buffer live in the top module.

## Test plan
All scenarios use default parameters, set stride 0x200, and random SRAM latency of 1–4 cycles.
1. Reset, then read 0x500 (SRAM[0x500]=0x11, SRAM[0x504]=0x22) → reads issued at 0x500 then 0x504. `ready` in `FILL` with `rdata`=0x11.
2. Then read 0x504 → `ready` the cycle after the request, `rdata`=0x22, no `sram_read_en`.
3. Write 0x500 ← 0xDEADBEEF → one SRAM write, `ready` on `sram_ready`. Re-read 0x500 hits with 0xDEADBEEF.
4. LRU test: read 0x500, 0x700, 0x500, then 0x900 → 0x900 evicts the 0x700 line. 0x500 then hits and 0x700 misses.
5. Write miss 0x1500 → SRAM write only. A following read of 0x1500 misses.
6. Assert `rst` in `REFILL` after beat 0 → next cycle all outputs 0. Re-read of the same address misses and refills both beats.
